// File: rtl/operand_pre_approx.sv
// Leading-one detect and significand truncation for the approximate multiplier; PRE_APPROX_ROUND_EN adds half-up rounding.
// Latency 2 cycles, throughput 1 pair/cycle.
// Backpressure: in_ready = !s1_valid || s1_advance (combinational from out_ready, no skid buffer).

module pre_approx_lane #(
    parameter int W  = 8,
    parameter int MD = 6,
    parameter int LW = 3,
    parameter int SW = 4
) (
    input  logic [W-1:0]  x_raw,
    output logic [LW-1:0] lead_raw,
    input  logic [W-1:0]  x,
    input  logic [LW-1:0] lead,
    output logic [MD-1:0] trunc,
    output logic [SW-1:0] shift
);
    logic [SW-1:0] sh_floor;
    logic [MD-1:0] tr_floor;

    // Highest set bit wins; a zero operand reports index 0.
    always_comb begin
        lead_raw = '0;
        for (int i = 0; i < W; i++) begin
            if (x_raw[i]) lead_raw = LW'(i);
        end
    end

    always_comb begin
        sh_floor = '0;
        if (int'(lead) >= MD) sh_floor = SW'(int'(lead) - (MD - 1));
        tr_floor = MD'(x >> sh_floor);
    end

`ifdef PRE_APPROX_ROUND_EN
    logic          rbit;
    logic [MD:0]   rnd;

    always_comb begin
        rbit  = (sh_floor != '0) ? 1'(x >> (sh_floor - SW'(1))) : 1'b0;
        rnd   = {1'b0, tr_floor} + {{MD{1'b0}}, rbit};
        trunc = rnd[MD-1:0];
        shift = sh_floor;
        // A carry out renormalises by one more bit unless the shift is already at its ceiling.
        if (rnd[MD]) begin
            if (int'(sh_floor) == W - MD) begin
                trunc = tr_floor;
            end else begin
                trunc = {1'b1, {(MD-1){1'b0}}};
                shift = sh_floor + SW'(1);
            end
        end
    end
`else
    assign trunc = tr_floor;
    assign shift = sh_floor;
`endif
endmodule

module operand_pre_approx #(
    parameter int A_BW    = 8,
    parameter int B_BW    = 8,
    parameter int MULT_DW = 6,
    parameter int SA_W    = $clog2(A_BW) + 1,
    parameter int SB_W    = $clog2(B_BW) + 1,
    parameter int ST_W    = $clog2(A_BW + B_BW) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_BW-1:0]    a_in,
    input  logic [B_BW-1:0]    b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MULT_DW-1:0] a_trunc,
    output logic [MULT_DW-1:0] b_trunc,
    output logic [SA_W-1:0]    a_shift,
    output logic [SB_W-1:0]    b_shift,
    output logic [ST_W-1:0]    shift_amt
);
    localparam int LA_W = (A_BW > 1) ? $clog2(A_BW) : 1;
    localparam int LB_W = (B_BW > 1) ? $clog2(B_BW) : 1;

    logic               s1_valid;
    logic               s1_advance;
    logic [A_BW-1:0]    s1_a;
    logic [B_BW-1:0]    s1_b;
    logic [LA_W-1:0]    s1_lead_a;
    logic [LB_W-1:0]    s1_lead_b;
    logic [LA_W-1:0]    lead_a_raw;
    logic [LB_W-1:0]    lead_b_raw;
    logic [MULT_DW-1:0] trunc_a_nxt;
    logic [MULT_DW-1:0] trunc_b_nxt;
    logic [SA_W-1:0]    shift_a_nxt;
    logic [SB_W-1:0]    shift_b_nxt;

    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;

    pre_approx_lane #(.W(A_BW), .MD(MULT_DW), .LW(LA_W), .SW(SA_W)) u_lane_a (
        .x_raw    (a_in),
        .lead_raw (lead_a_raw),
        .x        (s1_a),
        .lead     (s1_lead_a),
        .trunc    (trunc_a_nxt),
        .shift    (shift_a_nxt)
    );

    pre_approx_lane #(.W(B_BW), .MD(MULT_DW), .LW(LB_W), .SW(SB_W)) u_lane_b (
        .x_raw    (b_in),
        .lead_raw (lead_b_raw),
        .x        (s1_b),
        .lead     (s1_lead_b),
        .trunc    (trunc_b_nxt),
        .shift    (shift_b_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_lead_a <= '0;
            s1_lead_b <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid  <= 1'b1;
            s1_a      <= a_in;
            s1_b      <= b_in;
            s1_lead_a <= lead_a_raw;
            s1_lead_b <= lead_b_raw;
        end else if (s1_advance) begin
            s1_valid  <= 1'b0;
        end
    end

    // Outputs only change on a load, so they stay put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_trunc   <= '0;
            b_trunc   <= '0;
            a_shift   <= '0;
            b_shift   <= '0;
            shift_amt <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            a_trunc   <= trunc_a_nxt;
            b_trunc   <= trunc_b_nxt;
            a_shift   <= shift_a_nxt;
            b_shift   <= shift_b_nxt;
            shift_amt <= ST_W'(shift_a_nxt) + ST_W'(shift_b_nxt);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
